csdf_2p_sum_fwd: RTL and testbench

Cyclo-static two-phase dataflow actor that sits downstream of a multi-stream pick FIFO/actor pair and consumes its single output stream through a standard FIFO read interface. Phase 0 reads RATE0 tokens and emits their modular sum on output port 0. Phase 1 forwards RATE1 tokens unchanged on output port 1. The phases then repeat. Both outputs drive downstream FIFOs through the codebase's write/full handshake.

---
 rtl/csdf_2p_sum_fwd_if.sv | 29 ++
 rtl/csdf_2p_sum_fwd.sv | 95 +++++++++
 tb/tb_csdf_2p_sum_fwd.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/csdf_2p_sum_fwd_if.sv
// Handshake bundle for the two-phase sum/forward actor: one FIFO read side
// (first-word-fall-through) and two FIFO write sides with full flags.
interface csdf_2p_sum_fwd_if #(
  parameter int WIDTH = 8
);
  logic             in_empty;
  logic             in_read;
  logic [WIDTH-1:0] in_data;
  logic             out0_full;
  logic             out0_wr;
  logic [WIDTH-1:0] out0_data;
  logic             out1_full;
  logic             out1_wr;
  logic [WIDTH-1:0] out1_data;

  // Valid/ready semantics: a pop happens at the rising edge where in_read=1
  // (only ever asserted while in_empty=0); a write happens at the rising
  // edge where outN_wr=1 (only ever asserted while outN_full=0). Data is
  // meaningful only in a cycle whose strobe is 1.
  modport master (
    input  in_empty, in_data, out0_full, out1_full,
    output in_read, out0_wr, out0_data, out1_wr, out1_data
  );

  modport slave (
    output in_empty, in_data, out0_full, out1_full,
    input  in_read, out0_wr, out0_data, out1_wr, out1_data
  );
endinterface

// File: rtl/csdf_2p_sum_fwd.sv
// Cyclo-static two-phase actor: phase 0 sums RATE0 tokens onto output 0,
// phase 1 forwards RATE1 tokens unchanged onto output 1, then repeats.
module csdf_2p_sum_fwd #(
  parameter int WIDTH = 8,
  parameter int RATE0 = 2,
  parameter int RATE1 = 2
) (
  input  logic                  ck,
  input  logic                  rst,
  csdf_2p_sum_fwd_if.master     bus,
  output logic                  phase,
  output logic [1:0]            state_dbg
);
  localparam int MAXR = (RATE0 > RATE1) ? RATE0 : RATE1;
  localparam int CW   = $clog2(MAXR + 1);
  localparam logic [CW-1:0] LAST0 = CW'(RATE0 - 1);
  localparam logic [CW-1:0] LAST1 = CW'(RATE1 - 1);

  typedef enum logic [1:0] {
    S_ACC  = 2'd0,
    S_EMIT = 2'd1,
    S_FWD  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;

  assign phase     = (state == S_FWD);
  assign state_dbg = state;

  // Strobes are decoded from registered state and the live flags so that
  // phase 1 is a zero-latency pass-through; reset masks every strobe.
  always_comb begin
    bus.in_read   = 1'b0;
    bus.out0_wr   = 1'b0;
    bus.out1_wr   = 1'b0;
    bus.out0_data = acc;
    bus.out1_data = bus.in_data;
    if (rst) begin
      case (state)
        S_ACC:   bus.in_read = !bus.in_empty;
        S_EMIT:  bus.out0_wr = !bus.out0_full;
        S_FWD: begin
          bus.in_read = !bus.in_empty && !bus.out1_full;
          bus.out1_wr = !bus.in_empty && !bus.out1_full;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      state <= S_ACC;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_ACC: begin
          if (bus.in_read) begin
            acc <= acc + bus.in_data;
            if (cnt == LAST0) begin
              cnt   <= '0;
              state <= S_EMIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (bus.out0_wr) begin
            acc   <= '0;
            state <= S_FWD;
          end
        end
        S_FWD: begin
          // Counter only advances on a real transfer, so stalls hold position.
          if (bus.out1_wr) begin
            if (cnt == LAST1) begin
              cnt   <= '0;
              state <= S_ACC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_ACC;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csdf_2p_sum_fwd.sv
// Bench for csdf_2p_sum_fwd: upstream token queue, expected-value queues
// for both outputs, directed phase/timing checks and a randomised stall run.
module tb_csdf_2p_sum_fwd;
  localparam int W = 8;

  logic       ck;
  logic       rst;
  logic       phase;
  logic [1:0] state_dbg;

  csdf_2p_sum_fwd_if #(.WIDTH(W)) bus ();

  csdf_2p_sum_fwd #(.WIDTH(W), .RATE0(2), .RATE1(2)) dut (
    .ck        (ck),
    .rst       (rst),
    .bus       (bus),
    .phase     (phase),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // bench state
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] src_q[$];
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];

  logic rst_v, stall_in, full0, full1;
  logic s_in_read, s_out0_wr, s_out1_wr, s_phase;
  logic [W-1:0] s_out0_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Apply inputs at the falling edge, sample after settling, score writes,
  // and retire the head token if the DUT pops it at the next rising edge.
  task automatic step();
    logic [W-1:0] e;
    @(negedge ck);
    rst           = rst_v;
    bus.in_empty  = (src_q.size() == 0) || stall_in;
    bus.in_data   = (src_q.size() != 0) ? src_q[0] : '0;
    bus.out0_full = full0;
    bus.out1_full = full1;
    #1;
    cyc++;
    s_in_read   = bus.in_read;
    s_out0_wr   = bus.out0_wr;
    s_out1_wr   = bus.out1_wr;
    s_phase     = phase;
    s_out0_data = bus.out0_data;
    if (bus.out0_wr) begin
      if (exp0_q.size() == 0) check("out0_extra_write", 1, 0);
      else begin
        e = exp0_q.pop_front();
        check("out0_data", bus.out0_data, e);
      end
    end
    if (bus.out1_wr) begin
      if (exp1_q.size() == 0) check("out1_extra_write", 1, 0);
      else begin
        e = exp1_q.pop_front();
        check("out1_data", bus.out1_data, e);
      end
    end
    if (phase && rst) check("fwd_read_eq_wr", bus.in_read, bus.out1_wr);
    if (bus.in_read) begin
      if (src_q.size() == 0) check("pop_when_empty", 1, 0);
      else void'(src_q.pop_front());
    end
  endtask

  task automatic push_iter(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
    logic [W-1:0] s;
    s = a + b;
    src_q.push_back(a); src_q.push_back(b);
    src_q.push_back(c); src_q.push_back(d);
    exp0_q.push_back(s);
    exp1_q.push_back(c); exp1_q.push_back(d);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp0_q.size() != 0 || exp1_q.size() != 0) && n < 60) begin
      step();
      n++;
    end
    check(tag, (src_q.size() == 0 && exp0_q.size() == 0 && exp1_q.size() == 0), 1);
  endtask

  logic exp_phase[6]   = '{0, 0, 0, 1, 1, 0};
  logic exp_rd[6]      = '{1, 1, 0, 1, 1, 1};
  logic exp_wr0[6]     = '{0, 0, 1, 0, 0, 0};

  initial begin
    rst = 1'b0;
    rst_v = 1'b0; stall_in = 1'b0; full0 = 1'b0; full1 = 1'b0;
    bus.in_empty = 1'b1; bus.in_data = '0;
    bus.out0_full = 1'b0; bus.out1_full = 1'b0;

    // reset with tokens available: no strobes, phase 0
    push_iter(8'd3, 8'd5, 8'd7, 8'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_in_read", s_in_read, 0);
      check("rst_out0_wr", s_out0_wr, 0);
      check("rst_out1_wr", s_out1_wr, 0);
      check("rst_phase", s_phase, 0);
    end

    // basic iteration followed by the wrap-around iteration
    push_iter(8'd200, 8'd100, 8'd1, 8'd2);
    rst_v = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("basic_phase_c%0d", i + 1), s_phase, exp_phase[i]);
      check($sformatf("basic_in_read_c%0d", i + 1), s_in_read, exp_rd[i]);
      check($sformatf("basic_out0_wr_c%0d", i + 1), s_out0_wr, exp_wr0[i]);
    end
    drain("drain_basic_wrap");

    // backpressure on out0 after the second pop
    full0 = 1'b1;
    push_iter(8'd10, 8'd20, 8'd30, 8'd40);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp0_out0_wr", s_out0_wr, 0);
      check("bp0_in_read", s_in_read, 0);
      check("bp0_acc_held", s_out0_data, 30);
    end
    full0 = 1'b0;
    step();
    check("bp0_release_wr", s_out0_wr, 1);
    drain("drain_bp0");

    // phase-1 starvation/backpressure: alternate, then both together
    push_iter(8'd1, 8'd2, 8'd3, 8'd4);
    push_iter(8'd5, 8'd6, 8'd7, 8'd8);
    for (int i = 0; i < 10; i++) begin
      stall_in = i[0];
      full1    = !i[0];
      step();
    end
    stall_in = 1'b1; full1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("both_stall_in_read", s_in_read, 0);
      check("both_stall_out1_wr", s_out1_wr, 0);
    end
    stall_in = 1'b0; full1 = 1'b0;
    drain("drain_stall");
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_in_read", s_in_read, 0);
    end

    // randomised stalls on every flag
    for (int k = 0; k < 3; k++)
      push_iter(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 60; i++) begin
      stall_in = ($urandom_range(0, 3) == 0);
      full0    = ($urandom_range(0, 2) == 0);
      full1    = ($urandom_range(0, 2) == 0);
      step();
    end
    stall_in = 1'b0; full0 = 1'b0; full1 = 1'b0;
    drain("drain_random");

    // reset after one phase-0 pop discards the partial sum
    src_q.push_back(8'd99);
    step();
    check("midrst_first_pop", s_in_read, 1);
    rst_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("midrst_in_read", s_in_read, 0);
      check("midrst_phase", s_phase, 0);
    end
    rst_v = 1'b1;
    push_iter(8'd4, 8'd6, 8'd5, 8'd7);
    drain("drain_midrst");

    check("exp0_empty", exp0_q.size(), 0);
    check("exp1_empty", exp1_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
